instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage sitting directly upstream of the instruction decoder and driving the memory block's read port.
//  - Walks the program counter (PC) through memory.
//  - Reads one or two bytes per instruction and presents one assembled instruction to the decoder.
//  - Holds the instruction under a valid/ready handshake.
//  - Accepts branch/call/return redirects from the execute stage.
// PARAMETERS
//  MEM_DEPTH  24  number of addressable program bytes; PC wraps MEM_DEPTH-1 -> 0
//  RESET_PC   0   PC value loaded on reset
// PORTS
//  clk          in   1  single clock; all state changes on rising edge
//  rst          in   1  synchronous, active-high reset
//  mem_read     out  1  read strobe to memory
//  mem_addr     out  8  byte address to memory
//  mem_data     in   8  memory read data; valid the cycle after mem_read is asserted
//  instr_valid  out  1  assembled instruction available to decoder
//  instr_ready  in   1  decoder accepts instruction this cycle
//  opcode       out  4  byte0[7:4]
//  rd           out  2  byte0[3:2]
//  rs           out  2  byte0[1:0]
//  operand      out  8  byte1 for two-byte opcodes, else 8'h00
//  instr_pc     out  8  address of byte0
//  redirect     in   1  load redirect_pc and flush
//  redirect_pc  in   8  new PC target
//  fetch_err    out  1  one-cycle pulse: redirect_pc >= MEM_DEPTH
// BEHAVIOUR
//  Reset (rst=1 at edge):
//  - PC<=RESET_PC; state<=F_OP.
//  - All outputs 0, including mem_read; memory initialises under the same rst.
//  State machine:
//  - F_OP: mem_read=1, mem_addr=PC -> W_OP.
//  - W_OP: capture mem_data as byte0; PC<=PC+1 (wrap).
//    Two-byte opcodes (0011,0100,0101,1000,1001,1010) -> F_OPR; all others -> HOLD.
//  - F_OPR: mem_read=1, mem_addr=PC -> W_OPR.
//  - W_OPR: capture operand; PC<=PC+1 (wrap) -> HOLD.
//  - HOLD: instr_valid=1; fields stable. If instr_ready=1 -> F_OP, and instr_valid=0 next cycle.
//  mem_read is 0 in W_OP, W_OPR and HOLD; mem_addr holds its last value.
//  Latency from entering F_OP to instr_valid: one-byte = 2 cycles; two-byte = 4 cycles.
//  Throughput: one instruction per 3 or 5 cycles.
//  Redirect (any state; priority below rst only):
//  - PC<=redirect_pc; partial fetch discarded; instr_valid<=0; state<=F_OP.
//  - redirect together with instr_ready in HOLD: the instruction is consumed and the redirect is applied.
//  - redirect_pc >= MEM_DEPTH: PC<=0 and fetch_err=1 for one cycle.
//  Wrap: an operand byte at MEM_DEPTH-1 is followed by PC=0.
//  Reset mid-fetch (any state) aborts the fetch; no instr_valid follows until a full new fetch completes.
//  Opcode 1111 (undefined) is treated as one-byte and passed through; the decoder flags it.
// STRUCTURE
//  proc_pkg holds:
//  - opcode localparams (OP_ADD=4'b0000 ... OP_RET=4'b1011)
//  - state encoding
//  - function is_two_byte(opcode)
//  Sub-module instr_len_decode: combinational opcode -> two_byte flag, shared with the decoder.
//  PC register, byte registers and FSM live in instr_fetch; no other sub-modules.
// TESTING
//  1. Reset, memory preloaded with mem[0]=8'h01, ready=1 -> cycle 2: valid=1, opcode=0, rd=0, rs=1, operand=0, instr_pc=0.
//  2. PC=3 with mem[3]=8'h34, mem[4]=8'h03 -> 4 cycles later: opcode=3, rd=1, rs=0, operand=8'h03, instr_pc=3; PC=5.
//  3. Instruction in HOLD, ready=0 for 5 cycles -> valid stays 1, all fields constant, mem_read=0; ready=1 -> valid=0 next cycle.
//  4. redirect=1, redirect_pc=12 during W_OPR -> operand discarded; next valid instruction has instr_pc=12 and opcode=8.
//  5. PC=23 with a two-byte opcode at mem[23] -> operand read from addr 0; PC=1 afterwards.
//     Separately: redirect_pc=30 -> fetch_err pulse and next fetch at addr 0.
//  6. rst asserted in F_OPR -> next cycle all outputs 0 and PC=0; first valid instruction arrives 2 cycles after rst drops.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the processor front end: opcode encodings, the fetch
// state machine encoding and the instruction-length rule used by both the
// fetch stage and the decoder.
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  // Opcode map (byte0[7:4]). 4'b1111 is undefined and is passed through as
  // a one-byte instruction; the decoder is responsible for flagging it.
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OP_W-1:0] OP_LDI   = 4'b0011;
  localparam logic [OP_W-1:0] OP_LD    = 4'b0100;
  localparam logic [OP_W-1:0] OP_ST    = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0110;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_JMP   = 4'b1000;
  localparam logic [OP_W-1:0] OP_JZ    = 4'b1001;
  localparam logic [OP_W-1:0] OP_CALL  = 4'b1010;
  localparam logic [OP_W-1:0] OP_RET   = 4'b1011;
  localparam logic [OP_W-1:0] OP_UNDEF = 4'b1111;

  // Fetch sequencer states:
  //   F_OP  : strobe read of byte0     W_OP  : capture byte0
  //   F_OPR : strobe read of operand   W_OPR : capture operand
  //   HOLD  : present instruction to the decoder
  typedef enum logic [2:0] {
    F_OP  = 3'd0,
    W_OP  = 3'd1,
    F_OPR = 3'd2,
    W_OPR = 3'd3,
    HOLD  = 3'd4
  } fetch_state_e;

  // Opcodes that carry an 8-bit operand in the following byte.
  function automatic logic is_two_byte(input logic [OP_W-1:0] opcode);
    case (opcode)
      OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_CALL: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// -----------------------------------------------------------------------------
// instr_len_decode
// Combinational opcode -> instruction length decode, shared between the fetch
// stage and the decoder so both agree on which opcodes carry an operand byte.
//
// Ports:
//   opcode    in   4  opcode field (byte0[7:4])
//   two_byte  out  1  1 = opcode is followed by an operand byte
// -----------------------------------------------------------------------------
module instr_len_decode
  import proc_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            two_byte
);

  assign two_byte = is_two_byte(opcode);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage between program memory and the instruction decoder. Walks the
// PC through memory, reads one or two bytes per instruction, and holds the
// assembled instruction under a valid/ready handshake. Redirects from the
// execute stage reload the PC and abandon any fetch in progress.
//
// Ports:
//   clk          in   1  clock, all state changes on rising edge
//   rst          in   1  synchronous active-high reset
//   mem_read     out  1  read strobe to memory
//   mem_addr     out  8  byte address to memory
//   mem_data     in   8  read data, valid the cycle after mem_read
//   instr_valid  out  1  instruction available to decoder
//   instr_ready  in   1  decoder accepts instruction this cycle
//   opcode       out  4  byte0[7:4]
//   rd           out  2  byte0[3:2]
//   rs           out  2  byte0[1:0]
//   operand      out  8  byte1 for two-byte opcodes, else 8'h00
//   instr_pc     out  8  address of byte0
//   redirect     in   1  load redirect_pc and flush
//   redirect_pc  in   8  redirect target
//   fetch_err    out  1  one-cycle pulse: redirect target outside memory
// -----------------------------------------------------------------------------
module instr_fetch
  import proc_pkg::*;
#(
  parameter int              MEM_DEPTH = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OP_W-1:0]   opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] byte0_q, byte0_d;
  logic [DATA_W-1:0] byte1_q, byte1_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              fetch_err_q, fetch_err_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              two_byte;

  instr_len_decode u_len_decode (
    .opcode   (mem_data[7:4]),
    .two_byte (two_byte)
  );

  assign pc_inc = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    instr_pc_d  = instr_pc_q;
    fetch_err_d = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = mem_addr_q;
    instr_valid = 1'b0;

    case (state_q)
      F_OP: begin
        mem_read = 1'b1;
        mem_addr = pc_q;
        state_d  = W_OP;
      end
      W_OP: begin
        byte0_d    = mem_data;
        byte1_d    = '0;
        instr_pc_d = pc_q;
        pc_d       = pc_inc;
        state_d    = two_byte ? F_OPR : HOLD;
      end
      F_OPR: begin
        mem_read = 1'b1;
        mem_addr = pc_q;
        state_d  = W_OPR;
      end
      W_OPR: begin
        byte1_d = mem_data;
        pc_d    = pc_inc;
        state_d = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_d = F_OP;
      end
      default: state_d = F_OP;
    endcase

    // Redirect wins over the normal sequence; any half-assembled instruction
    // is abandoned because the FSM restarts at F_OP. An in-HOLD instruction
    // that is accepted in the same cycle is still consumed by the decoder.
    if (redirect) begin
      state_d = F_OP;
      if (redirect_pc > LAST_PC) begin
        pc_d        = '0;
        fetch_err_d = 1'b1;
      end else begin
        pc_d = redirect_pc;
      end
    end

    // The memory resets on the same rst, so no read is issued while it is
    // held; the address keeps its last value.
    if (rst) begin
      mem_read = 1'b0;
      mem_addr = mem_addr_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= F_OP;
      pc_q        <= RESET_PC;
      byte0_q     <= '0;
      byte1_q     <= '0;
      instr_pc_q  <= '0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      instr_pc_q  <= instr_pc_d;
      mem_addr_q  <= mem_addr;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign opcode    = byte0_q[7:4];
  assign rd        = byte0_q[3:2];
  assign rs        = byte0_q[1:0];
  assign operand   = byte1_q;
  assign instr_pc  = instr_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: a synchronous program memory model,
// a table of single-instruction vectors, hand-written corner-case sequences
// (reset, stall, redirect mid-fetch, bad redirect, reset mid-fetch) and a
// randomized run compared against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DEPTH = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] operand;
  logic [7:0] instr_pc;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       fetch_err;

  logic [7:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.MEM_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .operand     (operand),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rst) mem_data <= 8'h00;
    else if (mem_read) mem_data <= (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_two_byte(input logic [3:0] op);
    return op inside {4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
  endfunction

  function automatic logic [7:0] wrap_add(input logic [7:0] a, input int n);
    return 8'((int'(a) + n) % DEPTH);
  endfunction

  typedef struct {
    logic [7:0] pc;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] opr;
    int         lat;
    logic [7:0] next_pc;
  } vec_t;

  vec_t vecs[8];

  // Start a fetch at pc via redirect; on return the DUT sits in F_OP.
  task automatic start_at(input logic [7:0] pc);
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  // Wait (bounded) for instr_valid; returns cycles waited or -1.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_read"}, mem_read, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " valid"}, instr_valid, 0);
    check({tag, " opcode"}, opcode, 0);
    check({tag, " rd"}, rd, 0);
    check({tag, " rs"}, rs, 0);
    check({tag, " operand"}, operand, 0);
    check({tag, " instr_pc"}, instr_pc, 0);
    check({tag, " fetch_err"}, fetch_err, 0);
  endtask

  initial begin
    int lat;
    logic [3:0] h_opc;
    logic [7:0] h_opr;
    logic [7:0] m_pc;
    int         m_cnt;
    int         m_len;
    bit         m_err;
    logic [7:0] eb0, eb1;
    bit         exp_valid;

    vecs[0] = '{8'd0,  8'h01, 8'h00, 4'h0, 2'd0, 2'd1, 8'h00, 2, 8'd1};
    vecs[1] = '{8'd3,  8'h34, 8'h03, 4'h3, 2'd1, 2'd0, 8'h03, 4, 8'd5};
    vecs[2] = '{8'd10, 8'hF6, 8'h77, 4'hF, 2'd1, 2'd2, 8'h00, 2, 8'd11};
    vecs[3] = '{8'd23, 8'h9B, 8'h5A, 4'h9, 2'd2, 2'd3, 8'h5A, 4, 8'd1};
    vecs[4] = '{8'd7,  8'hB0, 8'h11, 4'hB, 2'd0, 2'd0, 8'h00, 2, 8'd8};
    vecs[5] = '{8'd12, 8'h8E, 8'h44, 4'h8, 2'd3, 2'd2, 8'h44, 4, 8'd14};
    vecs[6] = '{8'd22, 8'hA5, 8'hC3, 4'hA, 2'd1, 2'd1, 8'hC3, 4, 8'd0};
    vecs[7] = '{8'd16, 8'h4D, 8'h29, 4'h4, 2'd3, 2'd1, 8'h29, 4, 8'd18};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01;

    // ---- Reset state and first fetch after reset ----
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("post-reset mem_read", mem_read, 1);
    check("post-reset mem_addr", mem_addr, 0);
    @(negedge clk);
    check("post-reset cyc1 valid", instr_valid, 0);
    @(negedge clk);
    check("post-reset cyc2 valid", instr_valid, 1);
    check("post-reset opcode", opcode, 0);
    check("post-reset rd", rd, 0);
    check("post-reset rs", rs, 1);
    check("post-reset operand", operand, 0);
    check("post-reset instr_pc", instr_pc, 0);
    @(negedge clk);
    check("post-reset consumed valid", instr_valid, 0);
    check("post-reset next addr", mem_addr, 1);
    instr_ready = 1'b0;

    // ---- Table-driven single instructions ----
    foreach (vecs[i]) begin
      mem[vecs[i].pc] = vecs[i].b0;
      mem[wrap_add(vecs[i].pc, 1)] = vecs[i].b1;
      start_at(vecs[i].pc);
      check($sformatf("vec%0d fetch mem_read", i), mem_read, 1);
      check($sformatf("vec%0d fetch mem_addr", i), mem_addr, vecs[i].pc);
      wait_valid(lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d opcode", i), opcode, vecs[i].opc);
      check($sformatf("vec%0d rd", i), rd, vecs[i].rd);
      check($sformatf("vec%0d rs", i), rs, vecs[i].rs);
      check($sformatf("vec%0d operand", i), operand, vecs[i].opr);
      check($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].pc);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check($sformatf("vec%0d valid drop", i), instr_valid, 0);
      check($sformatf("vec%0d next pc", i), mem_addr, vecs[i].next_pc);
    end

    // ---- Stall in HOLD for 5 cycles ----
    mem[3] = 8'h34;
    mem[4] = 8'h03;
    start_at(8'd3);
    wait_valid(lat);
    check("stall latency", lat, 4);
    h_opc = opcode;
    h_opr = operand;
    for (int i = 0; i < 5; i++) begin
      check("stall valid", instr_valid, 1);
      check("stall opcode", opcode, 4'h3);
      check("stall operand", operand, 8'h03);
      check("stall instr_pc", instr_pc, 8'd3);
      check("stall mem_read", mem_read, 0);
      @(negedge clk);
    end
    check("stall opcode unchanged", opcode, h_opc);
    check("stall operand unchanged", operand, h_opr);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("stall release valid", instr_valid, 0);

    // ---- Redirect during W_OPR discards the operand ----
    mem[12] = 8'h8E;
    mem[13] = 8'h44;
    start_at(8'd3);                // F_OP
    repeat (3) @(negedge clk);     // W_OP, F_OPR, W_OPR
    check("redir W_OPR mem_read", mem_read, 0);
    check("redir W_OPR valid", instr_valid, 0);
    redirect    = 1'b1;
    redirect_pc = 8'd12;
    @(negedge clk);
    redirect = 1'b0;
    check("redir new addr", mem_addr, 8'd12);
    check("redir in-range no err", fetch_err, 0);
    wait_valid(lat);
    check("redir latency", lat, 4);
    check("redir instr_pc", instr_pc, 8'd12);
    check("redir opcode", opcode, 4'h8);
    check("redir operand", operand, 8'h44);

    // ---- Out-of-range redirect ----
    start_at(8'd30);
    check("bad redir fetch_err", fetch_err, 1);
    check("bad redir mem_read", mem_read, 1);
    check("bad redir mem_addr", mem_addr, 0);
    @(negedge clk);
    check("bad redir err pulse width", fetch_err, 0);

    // ---- Reset asserted in F_OPR ----
    mem[5] = 8'hA5;
    mem[6] = 8'hC3;
    mem[0] = 8'h01;
    start_at(8'd5);                // F_OP
    repeat (2) @(negedge clk);     // W_OP, F_OPR
    check("rst-mid F_OPR mem_read", mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst-mid");
    rst = 1'b0;
    #1;
    check("rst-mid restart addr", mem_addr, 0);
    @(negedge clk);
    check("rst-mid cyc1 valid", instr_valid, 0);
    @(negedge clk);
    check("rst-mid cyc2 valid", instr_valid, 1);
    check("rst-mid instr_pc", instr_pc, 0);
    check("rst-mid opcode", opcode, 0);
    check("rst-mid rs", rs, 1);

    // ---- Randomized run against instruction-level model ----
    // Model state: m_pc = address of the instruction being fetched,
    // m_cnt = cycles since its fetch started (valid once m_cnt == length).
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'd0;
    m_pc  = 8'd0;
    m_cnt = 0;
    m_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      eb0   = mem[m_pc];
      m_len = ref_two_byte(eb0[7:4]) ? 4 : 2;
      eb1   = (m_len == 4) ? mem[wrap_add(m_pc, 1)] : 8'h00;
      exp_valid = (m_cnt == m_len);
      check("rand valid", instr_valid, exp_valid);
      check("rand mem_read", mem_read, (m_cnt == 0) || (m_len == 4 && m_cnt == 2));
      check("rand fetch_err", fetch_err, m_err);
      if (m_cnt == 0) check("rand addr byte0", mem_addr, m_pc);
      if (m_len == 4 && m_cnt == 2) check("rand addr byte1", mem_addr, wrap_add(m_pc, 1));
      if (exp_valid) begin
        check("rand opcode", opcode, eb0[7:4]);
        check("rand rd", rd, eb0[3:2]);
        check("rand rs", rs, eb0[1:0]);
        check("rand operand", operand, eb1);
        check("rand instr_pc", instr_pc, m_pc);
      end

      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom_range(0, 31));

      m_err = 1'b0;
      if (redirect) begin
        if (int'(redirect_pc) >= DEPTH) begin
          m_pc  = 8'd0;
          m_err = 1'b1;
        end else begin
          m_pc = redirect_pc;
        end
        m_cnt = 0;
      end else if (m_cnt == m_len) begin
        if (instr_ready) begin
          m_pc  = wrap_add(m_pc, m_len / 2);
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
      end
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
